ps2_scan_port: RTL and testbench
================================

PS2_SCAN_PORT -- requirements
Module: ps2_scan_port

Interface
REQ-001 Parameter PORT_DATA, default 8'd3: port_id that returns the FIFO head scan code.
REQ-002 Parameter PORT_STATUS, default 8'd13: port_id that returns the status byte.
REQ-003 Parameter TIMEOUT, default 50000: clk cycles with no ps2c falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 ps2c  input  1  PS/2 clock from the keyboard, asynchronous.
REQ-007 ps2d  input  1  PS/2 data from the keyboard, asynchronous.
REQ-008 port_id  input  8  processor port address.
REQ-009 read_strobe  input  1  processor read qualifier, one cycle wide.
REQ-010 data_out  output  8  combinational read data; 8'h00 when port_id matches neither port.
REQ-011 key_ready  output  1  registered; high while the FIFO is not empty.

Function
REQ-012 ps2c and ps2d SHALL each pass through a 2-FF synchronizer; a falling edge is synchronized ps2c going from 1 to 0 between consecutive cycles.
REQ-013 The receive FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL advance only on falling edges (or on timeout).
REQ-014 IDLE: on a falling edge with ps2d=0 (start bit), go to DATA with bit counter 0; on a falling edge with ps2d=1, stay in IDLE.
REQ-015 DATA: shift ps2d in LSB first; after the 8th bit, go to PARITY.
REQ-016 PARITY: capture the parity bit and go to STOP.
REQ-017 STOP: the frame is valid if ps2d=1 and the 9 bits have odd parity; go to IDLE in either case.
REQ-018 A frame with bad parity or stop bit=0 SHALL set sticky ERR and SHALL NOT be pushed.
REQ-019 In any state other than IDLE, TIMEOUT cycles without a falling edge SHALL force IDLE, set ERR and discard partial data.
REQ-020 Prefix decode: a valid byte 8'hE0 sets ext_pend; a valid byte 8'hF0 sets brk_pend; neither prefix is pushed.
REQ-021 Any other valid byte SHALL be pushed as the 10-bit entry {ext_pend, brk_pend, code} one cycle after the STOP edge; ext_pend and brk_pend are then cleared.
REQ-022 The FIFO SHALL be 4 entries deep with 2-bit read and write pointers that wrap from 3 to 0, plus a 3-bit count.
REQ-023 Pop occurs when read_strobe=1, port_id=PORT_DATA and the FIFO is not empty; a pop with the FIFO empty has no effect.
REQ-024 Push when full with no simultaneous pop SHALL drop the entry and set sticky OVF; push and pop in the same cycle when full SHALL both occur, count unchanged, no OVF.
REQ-025 data_out for port PORT_DATA SHALL be the head code, or 8'h00 when empty; the value is valid in the same cycle as read_strobe.
REQ-026 data_out for port PORT_STATUS SHALL be {2'b00, head_ext, head_brk, OVF, ERR, full, not_empty}; head_ext and head_brk are 0 when empty.
REQ-027 read_strobe with port_id=PORT_STATUS SHALL clear ERR and OVF on the next edge; a set event in the same cycle SHALL win over the clear.
REQ-028 key_ready SHALL rise one cycle after the push cycle and fall one cycle after the pop that empties the FIFO.

Reset
REQ-029 reset SHALL put the FSM in IDLE and clear the bit counter, timeout counter, pointers, count, ERR, OVF, ext_pend, brk_pend and key_ready, and SHALL set both synchronizers to 1.
REQ-030 reset asserted mid-frame SHALL discard the frame; the next start bit is received normally.
REQ-031 FIFO contents need not be cleared; they are unreadable while count=0.

Verification
REQ-032 Frame 8'h1C, parity 0, stop 1 -> key_ready=1; status=8'h01; a data read returns 8'h1C; key_ready=0 after the pop.
REQ-033 Frames F0,1C -> one entry; status=8'h11; data=8'h1C. Frames E0,F0,75 -> status=8'h31; data=8'h75.
REQ-034 Frame 8'h1C with parity 1 -> no push; status=8'h04; a second status read returns 8'h00.
REQ-035 Five valid codes with no reads -> status=8'h0B; four pops return the first four codes in order; the fifth is lost.
REQ-036 Start bit plus 3 data bits, then idle for TIMEOUT+2 cycles -> FSM in IDLE, ERR=1; a following valid frame 8'h29 is received correctly.
REQ-037 FIFO full, a pop coinciding with the push cycle -> count stays 4, OVF=0; read order is preserved across pointer wrap.

Source files
------------

// File: rtl/ps2_scan_port.sv
// PS/2 keyboard receiver with E0/F0 prefix folding, a 4-entry scan-code FIFO
// and a two-port processor read interface (data and status).
module ps2_scan_port #(
  parameter logic [7:0] PORT_DATA   = 8'd3,
  parameter logic [7:0] PORT_STATUS = 8'd13,
  parameter int         TIMEOUT     = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] data_out,
  output logic       key_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic        ps2d_s1_q, ps2d_s2_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [TW-1:0] tmo_cnt_q;
  logic        rx_valid_q;
  logic [7:0]  rx_code_q;
  logic        ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic        err_q, err_d, ovf_q, ovf_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        key_ready_q;
  logic [9:0]  mem [0:3];

  logic fall, timeout, cnt_clr, shift_en, par_en, frame_good, frame_bad;
  logic is_e0, is_f0, push_req, push, pop, full, not_empty, ovf_set, err_set, stat_rd;
  logic [9:0] head;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
    end else begin
      ps2c_s1_q   <= ps2c;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2d;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign fall    = ps2c_prev_q & ~ps2c_s2_q;
  assign timeout = (state_q != IDLE) && !fall && (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!ps2d_s2_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr    = fall && (state_q == IDLE);
    shift_en   = fall && (state_q == DATA);
    par_en     = fall && (state_q == PARITY);
    frame_good = fall && (state_q == STOP) && ps2d_s2_q && (^{shift_q, parity_q});
    frame_bad  = fall && (state_q == STOP) && !(ps2d_s2_q && (^{shift_q, parity_q}));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (cnt_clr)       bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 3'd1;
      if (state_q == IDLE || fall) tmo_cnt_q <= '0;
      else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      rx_valid_q <= frame_good;
    end
    if (shift_en)   shift_q   <= {ps2d_s2_q, shift_q[7:1]};
    if (par_en)     parity_q  <= ps2d_s2_q;
    if (frame_good) rx_code_q <= shift_q;
  end

  assign is_e0     = (rx_code_q == 8'hE0);
  assign is_f0     = (rx_code_q == 8'hF0);
  assign push_req  = rx_valid_q && !is_e0 && !is_f0;
  assign full      = (count_q == 3'd4);
  assign not_empty = (count_q != 3'd0);
  assign pop       = read_strobe && (port_id == PORT_DATA) && not_empty;
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign err_set   = frame_bad || timeout;
  assign stat_rd   = read_strobe && (port_id == PORT_STATUS);

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (rx_valid_q && is_e0)      ext_pend_d = 1'b1;
    else if (push_req)            ext_pend_d = 1'b0;
    if (rx_valid_q && is_f0)      brk_pend_d = 1'b1;
    else if (push_req)            brk_pend_d = 1'b0;
    // Set events take priority over the status-read clear.
    err_d = err_q;
    ovf_d = ovf_q;
    if (stat_rd) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (err_set) err_d = 1'b1;
    if (ovf_set) ovf_d = 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_ready_q <= 1'b0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_ready_q <= (count_d != 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {ext_pend_q, brk_pend_q, rx_code_q};
  end

  assign head      = mem[rd_ptr_q];
  assign key_ready = key_ready_q;

  always_comb begin
    data_out = 8'h00;
    if (port_id == PORT_DATA) begin
      if (not_empty) data_out = head[7:0];
    end else if (port_id == PORT_STATUS) begin
      data_out = {2'b00, not_empty & head[9], not_empty & head[8], ovf_q, err_q, full, not_empty};
    end
  end

endmodule

// File: tb/tb_ps2_scan_port.sv
// Directed bench for ps2_scan_port: reads queue their expected byte, and a
// negedge monitor checks data_out whenever read_strobe is presented.
module tb_ps2_scan_port;

  localparam logic [7:0] PD   = 8'd3;
  localparam logic [7:0] PS   = 8'd13;
  localparam int         TMO  = 200;
  localparam int         HALF = 6;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, read_strobe, key_ready;
  logic [7:0] port_id, data_out;

  int checks = 0;
  int errors = 0;

  string      exp_name_q[$];
  logic [7:0] exp_val_q[$];
  string      mon_name;
  logic [7:0] mon_exp;

  ps2_scan_port #(.PORT_DATA(PD), .PORT_STATUS(PS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .port_id(port_id), .read_strobe(read_strobe),
    .data_out(data_out), .key_ready(key_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (read_strobe) begin
      checks++;
      if (exp_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: port=%0d data_out=%02h required=none", port_id, data_out);
      end else begin
        mon_name = exp_name_q.pop_front();
        mon_exp  = exp_val_q.pop_front();
        if (data_out !== mon_exp) begin
          errors++;
          $display("FAIL %s: port=%0d data_out=%02h required=%02h", mon_name, port_id, data_out, mon_exp);
        end else begin
          $display("read %s: port=%0d data_out=%02h ok", mon_name, port_id, data_out);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic [7:0] exp, input string name);
    exp_name_q.push_back(name);
    exp_val_q.push_back(exp);
  endtask

  task automatic rd(input logic [7:0] port, input logic [7:0] exp, input string name);
    port_id = port;
    read_strobe = 1'b1;
    expect_read(exp, name);
    tick(1);
    read_strobe = 1'b0;
    port_id = 8'hFF;
    tick(1);
  endtask

  task automatic chk_kr(input logic exp, input string name);
    checks++;
    if (key_ready !== exp) begin
      errors++;
      $display("FAIL %s: key_ready=%0b required=%0b", name, key_ready, exp);
    end else begin
      $display("check %s: key_ready=%0b ok", name, key_ready);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2d = b;
    tick(HALF);
    ps2c = 1'b0;
    tick(HALF);
    ps2c = 1'b1;
  endtask

  // pop_at_push lines a data read up with the cycle the frame is pushed.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input bit pop_at_push, input logic [7:0] pop_exp);
    logic p;
    p = (~^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(p);
    ps2d = ~bad_stop;
    tick(HALF);
    ps2c = 1'b0;
    if (pop_at_push) begin
      tick(3);
      port_id = PD;
      read_strobe = 1'b1;
      expect_read(pop_exp, "pop_at_push_cycle");
      tick(1);
      read_strobe = 1'b0;
      port_id = 8'hFF;
      tick(HALF - 4);
    end else begin
      tick(HALF);
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(8);
  endtask

  task automatic send(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic partial_frame();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
  endtask

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; read_strobe = 1'b0; port_id = 8'hFF;
    tick(4);
    reset = 1'b0;
    tick(2);
    chk_kr(1'b0, "reset_key_ready");
    rd(PS, 8'h00, "reset_status");
    rd(PD, 8'h00, "reset_data_empty");
    rd(8'h07, 8'h00, "unmapped_port");

    send(8'h1C);
    chk_kr(1'b1, "kr_after_push");
    rd(PS, 8'h01, "status_one_entry");
    rd(PD, 8'h1C, "data_1c");
    chk_kr(1'b0, "kr_after_pop");
    rd(PD, 8'h00, "pop_when_empty");
    rd(PS, 8'h00, "status_after_empty_pop");

    send(8'hF0); send(8'h1C);
    rd(PS, 8'h11, "status_break");
    rd(PD, 8'h1C, "data_break_1c");
    send(8'hE0); send(8'hF0); send(8'h75);
    rd(PS, 8'h31, "status_ext_break");
    rd(PD, 8'h75, "data_ext_break_75");
    rd(PS, 8'h00, "status_prefix_cleared");

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 8'h00);
    rd(PS, 8'h04, "status_bad_parity");
    rd(PS, 8'h00, "status_err_cleared");
    chk_kr(1'b0, "kr_no_push_bad_parity");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 8'h00);
    rd(PS, 8'h04, "status_bad_stop");
    rd(PS, 8'h00, "status_err_cleared2");

    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk_kr(1'b1, "kr_full");
    rd(PS, 8'h0B, "status_overflow");
    rd(PD, 8'h15, "ovf_pop1");
    rd(PD, 8'h1D, "ovf_pop2");
    rd(PD, 8'h24, "ovf_pop3");
    rd(PD, 8'h2D, "ovf_pop4");
    rd(PS, 8'h00, "status_after_drain");
    chk_kr(1'b0, "kr_after_drain");

    partial_frame();
    rd(PS, 8'h00, "partial_no_err_yet");
    tick(TMO + 2);
    rd(PS, 8'h04, "status_timeout");
    send(8'h29);
    rd(PS, 8'h01, "status_after_timeout");
    rd(PD, 8'h29, "data_29");

    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    send_frame(8'h2E, 1'b0, 1'b0, 1'b1, 8'h16);
    rd(PS, 8'h03, "status_full_push_pop");
    rd(PD, 8'h1E, "wrap_pop1");
    rd(PD, 8'h26, "wrap_pop2");
    rd(PD, 8'h25, "wrap_pop3");
    rd(PD, 8'h2E, "wrap_pop4");
    rd(PS, 8'h00, "status_wrap_empty");

    partial_frame();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    send(8'h1C);
    rd(PS, 8'h01, "status_after_midframe_reset");
    rd(PD, 8'h1C, "data_after_midframe_reset");

    tick(2);
    if (exp_val_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_reads: outstanding=%0d required=0", exp_val_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
